// File: rtl/retire_queue.sv
`default_nettype none
// ============================================================================
//  Module   : retire_queue
//  Purpose  : In-order retire buffer; dual-lane allocate and writeback,
//             up to four entries retired per cycle through registered lanes.
//  Revision : 1.0
// ============================================================================
module retire_queue #(
    parameter int DEPTH    = 16,
    parameter int RETIRE_W = 4,
    parameter int AR_W     = 5,
    parameter int PR_W     = 7,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic            Clk,
    input  logic            Rest,
    input  logic            ArchSStop,
    input  logic            ArchSFlash,
    input  logic            AllocReq1,
    input  logic            AllocReq2,
    input  logic            AllocDst1,
    input  logic            AllocDst2,
    input  logic [AR_W-1:0] AllocAR1,
    input  logic [AR_W-1:0] AllocAR2,
    input  logic [PR_W-1:0] AllocPR1,
    input  logic [PR_W-1:0] AllocPR2,
    input  logic [PR_W-1:0] AllocOldPR1,
    input  logic [PR_W-1:0] AllocOldPR2,
    output logic            AllocReady,
    output logic [IW-1:0]   AllocIdx1,
    output logic [IW-1:0]   AllocIdx2,
    input  logic            Wb1Able,
    input  logic            Wb2Able,
    input  logic [IW-1:0]   Wb1Idx,
    input  logic [IW-1:0]   Wb2Idx,
    output logic            RetireReg1Able,
    output logic            RetireReg2Able,
    output logic            RetireReg3Able,
    output logic            RetireReg4Able,
    output logic [AR_W-1:0] RetireAR1Addr,
    output logic [AR_W-1:0] RetireAR2Addr,
    output logic [AR_W-1:0] RetireAR3Addr,
    output logic [AR_W-1:0] RetireAR4Addr,
    output logic [PR_W-1:0] RetirePR1Addr,
    output logic [PR_W-1:0] RetirePR2Addr,
    output logic [PR_W-1:0] RetirePR3Addr,
    output logic [PR_W-1:0] RetirePR4Addr,
    output logic [PR_W-1:0] RetireOldPR1,
    output logic [PR_W-1:0] RetireOldPR2,
    output logic [PR_W-1:0] RetireOldPR3,
    output logic [PR_W-1:0] RetireOldPR4,
    output logic            RetireFree1,
    output logic            RetireFree2,
    output logic            RetireFree3,
    output logic            RetireFree4,
    output logic [2:0]      RetireNum
);

    localparam int CW    = IW + 1;
    localparam int LANES = 4;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_complete;
    logic [DEPTH-1:0] r_dst;
    logic [AR_W-1:0]  r_ar    [DEPTH];
    logic [PR_W-1:0]  r_pr    [DEPTH];
    logic [PR_W-1:0]  r_oldpr [DEPTH];
    logic [CW-1:0]    r_head;
    logic [CW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    logic             r_ret_dst [LANES];
    logic [AR_W-1:0]  r_ret_ar  [LANES];
    logic [PR_W-1:0]  r_ret_pr  [LANES];
    logic [PR_W-1:0]  r_ret_old [LANES];
    logic [2:0]       r_ret_num;

    logic             w_acc1;
    logic             w_acc2;
    logic [1:0]       w_acc_num;
    logic [IW-1:0]    w_tidx1;
    logic [IW-1:0]    w_tidx2;
    logic [IW-1:0]    w_ridx [LANES];
    logic [2:0]       w_n;
    logic             w_run;

    // Readiness looks only at the current count, so a full buffer that is
    // retiring this cycle still refuses allocation.
    assign AllocReady = (r_count <= CW'(DEPTH - 2));
    assign w_tidx1    = r_tail[IW-1:0];
    assign w_tidx2    = r_tail[IW-1:0] + IW'(1);
    assign AllocIdx1  = w_tidx1;
    assign AllocIdx2  = w_tidx2;

    assign w_acc1    = AllocReq1 & AllocReady & ~ArchSStop & ~ArchSFlash;
    assign w_acc2    = w_acc1 & AllocReq2;
    assign w_acc_num = {1'b0, w_acc1} + {1'b0, w_acc2};

    always_comb begin
        w_n   = '0;
        w_run = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            w_ridx[j] = r_head[IW-1:0] + IW'(j);
            if (w_run && (j < RETIRE_W) && (r_count > CW'(j)) &&
                r_valid[w_ridx[j]] && r_complete[w_ridx[j]]) begin
                w_n = 3'(j + 1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            r_valid    <= '0;
            r_complete <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_ret_num  <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_ret_dst[k] <= 1'b0;
                r_ret_ar[k]  <= '0;
                r_ret_pr[k]  <= '0;
                r_ret_old[k] <= '0;
            end
        end else begin
            r_ret_num <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_ret_dst[k] <= 1'b0;
                r_ret_ar[k]  <= '0;
                r_ret_pr[k]  <= '0;
                r_ret_old[k] <= '0;
            end
            if (!ArchSStop && ArchSFlash) begin
                r_valid    <= '0;
                r_complete <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
            end else if (!ArchSStop) begin
                if (Wb1Able && r_valid[Wb1Idx]) r_complete[Wb1Idx] <= 1'b1;
                if (Wb2Able && r_valid[Wb2Idx]) r_complete[Wb2Idx] <= 1'b1;
                // Retired slots are cleared after writeback so a late strobe
                // cannot resurrect them.
                for (int k = 0; k < LANES; k++) begin
                    if (3'(k) < w_n) begin
                        r_valid[w_ridx[k]]    <= 1'b0;
                        r_complete[w_ridx[k]] <= 1'b0;
                        r_ret_dst[k]          <= r_dst[w_ridx[k]];
                        r_ret_ar[k]           <= r_ar[w_ridx[k]];
                        r_ret_pr[k]           <= r_pr[w_ridx[k]];
                        r_ret_old[k]          <= r_oldpr[w_ridx[k]];
                    end
                end
                if (w_acc1) begin
                    r_valid[w_tidx1]    <= 1'b1;
                    r_complete[w_tidx1] <= 1'b0;
                end
                if (w_acc2) begin
                    r_valid[w_tidx2]    <= 1'b1;
                    r_complete[w_tidx2] <= 1'b0;
                end
                r_head    <= r_head + CW'(w_n);
                r_tail    <= r_tail + CW'(w_acc_num);
                r_count   <= r_count + CW'(w_acc_num) - CW'(w_n);
                r_ret_num <= w_n;
            end
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge Clk) begin
        if (w_acc1) begin
            r_dst[w_tidx1]   <= AllocDst1;
            r_ar[w_tidx1]    <= AllocAR1;
            r_pr[w_tidx1]    <= AllocPR1;
            r_oldpr[w_tidx1] <= AllocOldPR1;
        end
        if (w_acc2) begin
            r_dst[w_tidx2]   <= AllocDst2;
            r_ar[w_tidx2]    <= AllocAR2;
            r_pr[w_tidx2]    <= AllocPR2;
            r_oldpr[w_tidx2] <= AllocOldPR2;
        end
    end

    assign RetireNum      = r_ret_num;
    assign RetireReg1Able = r_ret_dst[0];
    assign RetireReg2Able = r_ret_dst[1];
    assign RetireReg3Able = r_ret_dst[2];
    assign RetireReg4Able = r_ret_dst[3];
    assign RetireFree1    = r_ret_dst[0];
    assign RetireFree2    = r_ret_dst[1];
    assign RetireFree3    = r_ret_dst[2];
    assign RetireFree4    = r_ret_dst[3];
    assign RetireAR1Addr  = r_ret_ar[0];
    assign RetireAR2Addr  = r_ret_ar[1];
    assign RetireAR3Addr  = r_ret_ar[2];
    assign RetireAR4Addr  = r_ret_ar[3];
    assign RetirePR1Addr  = r_ret_pr[0];
    assign RetirePR2Addr  = r_ret_pr[1];
    assign RetirePR3Addr  = r_ret_pr[2];
    assign RetirePR4Addr  = r_ret_pr[3];
    assign RetireOldPR1   = r_ret_old[0];
    assign RetireOldPR2   = r_ret_old[1];
    assign RetireOldPR3   = r_ret_old[2];
    assign RetireOldPR4   = r_ret_old[3];

endmodule
`default_nettype wire

// File: tb/tb_retire_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_retire_queue
//  Purpose  : Directed scoreboard bench for retire_queue.
//  Revision : 1.0
// ============================================================================
module tb_retire_queue;

    logic       Clk, Rest, ArchSStop, ArchSFlash;
    logic       AllocReq1, AllocReq2, AllocDst1, AllocDst2;
    logic [4:0] AllocAR1, AllocAR2;
    logic [6:0] AllocPR1, AllocPR2, AllocOldPR1, AllocOldPR2;
    logic       AllocReady;
    logic [3:0] AllocIdx1, AllocIdx2;
    logic       Wb1Able, Wb2Able;
    logic [3:0] Wb1Idx, Wb2Idx;
    logic       RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able;
    logic [4:0] RetireAR1Addr, RetireAR2Addr, RetireAR3Addr, RetireAR4Addr;
    logic [6:0] RetirePR1Addr, RetirePR2Addr, RetirePR3Addr, RetirePR4Addr;
    logic [6:0] RetireOldPR1, RetireOldPR2, RetireOldPR3, RetireOldPR4;
    logic       RetireFree1, RetireFree2, RetireFree3, RetireFree4;
    logic [2:0] RetireNum;

    retire_queue #(.DEPTH(16), .RETIRE_W(4), .AR_W(5), .PR_W(7)) dut (
        .Clk(Clk), .Rest(Rest), .ArchSStop(ArchSStop), .ArchSFlash(ArchSFlash),
        .AllocReq1(AllocReq1), .AllocReq2(AllocReq2),
        .AllocDst1(AllocDst1), .AllocDst2(AllocDst2),
        .AllocAR1(AllocAR1), .AllocAR2(AllocAR2),
        .AllocPR1(AllocPR1), .AllocPR2(AllocPR2),
        .AllocOldPR1(AllocOldPR1), .AllocOldPR2(AllocOldPR2),
        .AllocReady(AllocReady), .AllocIdx1(AllocIdx1), .AllocIdx2(AllocIdx2),
        .Wb1Able(Wb1Able), .Wb2Able(Wb2Able), .Wb1Idx(Wb1Idx), .Wb2Idx(Wb2Idx),
        .RetireReg1Able(RetireReg1Able), .RetireReg2Able(RetireReg2Able),
        .RetireReg3Able(RetireReg3Able), .RetireReg4Able(RetireReg4Able),
        .RetireAR1Addr(RetireAR1Addr), .RetireAR2Addr(RetireAR2Addr),
        .RetireAR3Addr(RetireAR3Addr), .RetireAR4Addr(RetireAR4Addr),
        .RetirePR1Addr(RetirePR1Addr), .RetirePR2Addr(RetirePR2Addr),
        .RetirePR3Addr(RetirePR3Addr), .RetirePR4Addr(RetirePR4Addr),
        .RetireOldPR1(RetireOldPR1), .RetireOldPR2(RetireOldPR2),
        .RetireOldPR3(RetireOldPR3), .RetireOldPR4(RetireOldPR4),
        .RetireFree1(RetireFree1), .RetireFree2(RetireFree2),
        .RetireFree3(RetireFree3), .RetireFree4(RetireFree4),
        .RetireNum(RetireNum)
    );

    // One expected retire event: the cycle it must appear in, the count and
    // all four lanes packed as {able, free, ar, pr, oldpr}, lane 1 lowest.
    typedef struct packed {
        logic [31:0] cyc;
        logic [2:0]  num;
        logic [83:0] lanes;
    } exp_t;

    exp_t q[$];
    exp_t stg;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [20:0] lane_of(input logic d, input logic [4:0] ar,
                                            input logic [6:0] pr, input logic [6:0] old);
        return {d, d, ar, pr, old};
    endfunction

    // Standard payload used for most entries: AR=i, PR=64+i, OldPR=32+i.
    function automatic logic [20:0] std_lane(input int i);
        return lane_of(1'b1, 5'(i), 7'(64 + i), 7'(32 + i));
    endfunction

    task automatic set_lane(input int k, input logic [20:0] v);
        stg.lanes[k*21 +: 21] = v;
    endtask

    task automatic push_exp(input int c, input int n);
        stg.cyc = 32'(c);
        stg.num = 3'(n);
        q.push_back(stg);
        stg = '0;
    endtask

    always @(negedge Clk) begin
        logic [83:0] act;
        exp_t e;
        act = {RetireReg4Able, RetireFree4, RetireAR4Addr, RetirePR4Addr, RetireOldPR4,
               RetireReg3Able, RetireFree3, RetireAR3Addr, RetirePR3Addr, RetireOldPR3,
               RetireReg2Able, RetireFree2, RetireAR2Addr, RetirePR2Addr, RetireOldPR2,
               RetireReg1Able, RetireFree1, RetireAR1Addr, RetirePR1Addr, RetireOldPR1};
        if (RetireNum != 3'd0 || act != '0) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_retire: got num=%0d lanes=%0h want none (cycle %0d)",
                         RetireNum, act, cyc);
            end else begin
                e = q.pop_front();
                chk("retire_cycle", 64'(cyc), 64'(e.cyc));
                chk("retire_num", 64'(RetireNum), 64'(e.num));
                for (int k = 0; k < 4; k++)
                    chk($sformatf("retire_lane%0d", k + 1), 64'(act[k*21 +: 21]),
                        64'(e.lanes[k*21 +: 21]));
            end
        end else if (q.size() != 0 && int'(q[0].cyc) <= cyc) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_retire: got none want num=%0d at cycle %0d", e.num, e.cyc);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_alloc(input logic r1, input logic r2, input logic d1, input logic d2,
                            input logic [4:0] a1, input logic [4:0] a2,
                            input logic [6:0] p1, input logic [6:0] p2,
                            input logic [6:0] o1, input logic [6:0] o2);
        AllocReq1 = r1; AllocReq2 = r2; AllocDst1 = d1; AllocDst2 = d2;
        AllocAR1 = a1; AllocAR2 = a2; AllocPR1 = p1; AllocPR2 = p2;
        AllocOldPR1 = o1; AllocOldPR2 = o2;
        tick();
        AllocReq1 = 1'b0; AllocReq2 = 1'b0;
    endtask

    task automatic alloc_std(input int i, input logic two);
        do_alloc(1'b1, two, 1'b1, 1'b1, 5'(i), 5'(i + 1), 7'(64 + i), 7'(65 + i),
                 7'(32 + i), 7'(33 + i));
    endtask

    task automatic do_wb(input logic e1, input logic [3:0] i1, input logic e2, input logic [3:0] i2);
        Wb1Able = e1; Wb1Idx = i1; Wb2Able = e2; Wb2Idx = i2;
        tick();
        Wb1Able = 1'b0; Wb2Able = 1'b0;
    endtask

    initial begin
        stg = '0;
        Rest = 1'b1; ArchSStop = 1'b0; ArchSFlash = 1'b0;
        AllocReq1 = 1'b0; AllocReq2 = 1'b0; AllocDst1 = 1'b0; AllocDst2 = 1'b0;
        AllocAR1 = '0; AllocAR2 = '0; AllocPR1 = '0; AllocPR2 = '0;
        AllocOldPR1 = '0; AllocOldPR2 = '0;
        Wb1Able = 1'b0; Wb2Able = 1'b0; Wb1Idx = '0; Wb2Idx = '0;
        tick(); tick();
        Rest = 1'b0;
        chk("reset_ready", 64'(AllocReady), 64'd1);
        chk("reset_num", 64'(RetireNum), 64'd0);
        chk("reset_idx1", 64'(AllocIdx1), 64'd0);
        chk("reset_idx2", 64'(AllocIdx2), 64'd1);

        // Two-entry alloc and same-cycle double writeback.
        do_alloc(1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd5, 7'd40, 7'd41, 7'd3, 7'd5);
        chk("idx_after_pair", 64'(AllocIdx1), 64'd2);
        do_wb(1'b1, 4'd0, 1'b1, 4'd1);
        set_lane(0, lane_of(1'b1, 5'd3, 7'd40, 7'd3));
        set_lane(1, lane_of(1'b1, 5'd5, 7'd41, 7'd5));
        push_exp(cyc + 1, 2);
        tick(); tick();

        // Six entries at 2..7; completion gap at 5 caps the first retire at 3.
        chk("idx_before_six", 64'(AllocIdx1), 64'd2);
        alloc_std(2, 1'b1); alloc_std(4, 1'b1); alloc_std(6, 1'b1);
        do_wb(1'b1, 4'd4, 1'b1, 4'd6);
        do_wb(1'b1, 4'd7, 1'b0, 4'd0);
        do_wb(1'b1, 4'd2, 1'b1, 4'd3);
        set_lane(0, std_lane(2)); set_lane(1, std_lane(3)); set_lane(2, std_lane(4));
        push_exp(cyc + 1, 3);
        tick();
        do_wb(1'b1, 4'd5, 1'b0, 4'd0);
        set_lane(0, std_lane(5)); set_lane(1, std_lane(6)); set_lane(2, std_lane(7));
        push_exp(cyc + 1, 3);
        tick(); tick();

        // Entry without a destination still counts but raises no lane flags.
        chk("idx_nodst", 64'(AllocIdx1), 64'd8);
        do_alloc(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 5'd0, 7'd60, 7'd0, 7'd61, 7'd0);
        do_wb(1'b1, 4'd8, 1'b0, 4'd0);
        set_lane(0, lane_of(1'b0, 5'd9, 7'd60, 7'd61));
        push_exp(cyc + 1, 1);
        tick(); tick();

        // Flash with five entries, three complete, plus a dropped writeback/alloc.
        alloc_std(9, 1'b1); alloc_std(11, 1'b1); alloc_std(13, 1'b0);
        chk("idx_before_flash", 64'(AllocIdx1), 64'd14);
        do_wb(1'b1, 4'd10, 1'b1, 4'd11);
        do_wb(1'b1, 4'd12, 1'b0, 4'd0);
        ArchSFlash = 1'b1;
        Wb1Able = 1'b1; Wb1Idx = 4'd9;
        AllocReq1 = 1'b1;
        tick();
        ArchSFlash = 1'b0; Wb1Able = 1'b0; AllocReq1 = 1'b0;
        chk("flash_idx1", 64'(AllocIdx1), 64'd0);
        chk("flash_idx2", 64'(AllocIdx2), 64'd1);
        chk("flash_ready", 64'(AllocReady), 64'd1);
        tick(); tick();

        // Fill all sixteen slots from index 0.
        for (int p = 0; p < 8; p++) begin
            if (p == 7) chk("ready_at_14", 64'(AllocReady), 64'd1);
            alloc_std(2 * p, 1'b1);
        end
        chk("full_ready", 64'(AllocReady), 64'd0);
        chk("full_idx1", 64'(AllocIdx1), 64'd0);
        chk("full_idx2", 64'(AllocIdx2), 64'd1);
        do_alloc(1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 5'd31, 7'd127, 7'd127, 7'd127, 7'd127);
        chk("full_reject_idx", 64'(AllocIdx1), 64'd0);
        do_wb(1'b1, 4'd2, 1'b1, 4'd3);
        do_wb(1'b1, 4'd0, 1'b1, 4'd1);
        for (int k = 0; k < 4; k++) set_lane(k, std_lane(k));
        push_exp(cyc + 1, 4);
        chk("full_retiring_ready", 64'(AllocReady), 64'd0);
        do_alloc(1'b1, 1'b1, 1'b1, 1'b1, 5'd31, 5'd31, 7'd127, 7'd127, 7'd127, 7'd127);
        chk("after_retire_ready", 64'(AllocReady), 64'd1);
        chk("wrap_idx1", 64'(AllocIdx1), 64'd0);
        chk("wrap_idx2", 64'(AllocIdx2), 64'd1);
        do_alloc(1'b1, 1'b1, 1'b1, 1'b1, 5'd20, 5'd21, 7'd100, 7'd101, 7'd110, 7'd111);
        chk("wrap_alloc_idx", 64'(AllocIdx1), 64'd2);

        // Stop holds four complete entries; Flash under Stop is ignored.
        do_wb(1'b1, 4'd6, 1'b1, 4'd7);
        do_wb(1'b1, 4'd4, 1'b1, 4'd5);
        ArchSStop = 1'b1; ArchSFlash = 1'b1;
        tick();
        ArchSFlash = 1'b0;
        tick(); tick();
        ArchSStop = 1'b0;
        for (int k = 0; k < 4; k++) set_lane(k, std_lane(4 + k));
        push_exp(cyc + 1, 4);
        tick(); tick();

        // Asynchronous reset while retire lanes are driven.
        do_wb(1'b1, 4'd8, 1'b1, 4'd9);
        set_lane(0, std_lane(8)); set_lane(1, std_lane(9));
        push_exp(cyc + 1, 2);
        tick();
        @(negedge Clk);
        #1;
        Rest = 1'b1;
        #1;
        chk("rest_num", 64'(RetireNum), 64'd0);
        chk("rest_lane1", 64'({RetireReg1Able, RetireFree1, RetireAR1Addr}), 64'd0);
        chk("rest_ready", 64'(AllocReady), 64'd1);
        chk("rest_idx1", 64'(AllocIdx1), 64'd0);
        tick();
        Rest = 1'b0;
        do_wb(1'b1, 4'd10, 1'b0, 4'd0);
        tick(); tick();

        // Recovery: a fresh entry lands at index 0 and retires normally.
        chk("post_rest_idx", 64'(AllocIdx1), 64'd0);
        do_alloc(1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 5'd0, 7'd70, 7'd0, 7'd71, 7'd0);
        do_wb(1'b1, 4'd0, 1'b0, 4'd0);
        set_lane(0, lane_of(1'b1, 5'd7, 7'd70, 7'd71));
        push_exp(cyc + 1, 1);
        repeat (4) tick();

        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/retire_queue.md
RETIRE_QUEUE -- requirements
Module: retire_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning number of in-order retire entries (power of two).
REQ-002 The block SHALL have parameter RETIRE_W, default 4, meaning maximum entries retired per cycle.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: Clk  in  1  rising-edge clock.
REQ-004 Rest  in  1  asynchronous reset, active-high.
REQ-005 ArchSStop  in  1  freeze all state; highest priority after reset.
REQ-006 ArchSFlash  in  1  flush all entries.
REQ-007 AllocReq1, AllocReq2  in  1 each  allocate request, lane 1 older than lane 2.
REQ-008 AllocDst1/2  in  1  entry writes an architectural register.
REQ-009 AllocAR1/2  in  `ArchRegBUs (5)  destination architectural register.
REQ-010 AllocPR1/2  in  `ReNameRegBUs (7)  new physical register.
REQ-011 AllocOldPR1/2  in  `ReNameRegBUs (7)  previous mapping, freed at retire.
REQ-012 AllocReady  out  1  at least two free entries (combinational from count).
REQ-013 AllocIdx1/2  out  log2(DEPTH)  entry index granted to lane 1/2.
REQ-014 Wb1Able, Wb2Able  in  1  completion strobe; Wb1Idx, Wb2Idx  in  log2(DEPTH)  completed entry.
REQ-015 RetireReg1Able..RetireReg4Able  out  1  registered retire lane valid with destination.
REQ-016 RetireAR1Addr..RetireAR4Addr  out  `ArchRegBUs; RetirePR1Addr..RetirePR4Addr  out  `ReNameRegBUs.
REQ-017 RetireOldPR1..RetireOldPR4  out  `ReNameRegBUs  physical register to return to free list; RetireFree1..4  out  1  valid.
REQ-018 RetireNum  out  3  number of entries retired (0..4), including no-destination entries.

Function
REQ-019 Storage: circular buffer; head/tail pointers log2(DEPTH)+1 bits with wrap bit; count 0..DEPTH.
REQ-020 Allocation accepted only when AllocReady=1 and not Stop/Flash; AllocReq2 without AllocReq1 is ignored.
REQ-021 Accepted lane 1 writes entry tail, lane 2 writes tail+1 (mod DEPTH); entry valid=1, complete=0; tail advances by accepted count.
REQ-022 AllocIdx1 = tail[index], AllocIdx2 = tail+1 [index], combinational.
REQ-023 Writeback sets complete=1 at Wb idx next edge; writeback to an invalid entry is ignored; both ports to same index legal.
REQ-024 Retire count n = number of consecutive valid, complete entries starting at head (registered complete bits), capped at RETIRE_W and count.
REQ-025 Lane k (k<=n) outputs entry head+k-1 in program order, lane 1 oldest; RetireRegkAble=RetireFreek=AllocDst of that entry; lanes k>n drive Able/Free 0, addresses 0.
REQ-026 Retire outputs registered: valid one cycle after the edge where the entry was complete; head advances by n, entries cleared.
REQ-027 Writeback to the head entry in cycle t retires it at earliest in cycle t+1 evaluation (outputs at t+2).
REQ-028 Simultaneous alloc and retire: count_next = count + accepted - n; full buffer retiring still rejects alloc that cycle (AllocReady from current count).
REQ-029 ArchSStop=1: no alloc, writeback or retire; all state held; next-cycle retire outputs and RetireNum = 0.
REQ-030 ArchSFlash=1 (Stop=0): all valid bits cleared, head=tail=0, count=0; pending writebacks dropped; next-cycle retire outputs 0.

Reset
REQ-031 Rest=1 asynchronously clears valid/complete bits, head, tail, count to 0, and all retire outputs, RetireNum to 0; AllocReady=1 after reset.
REQ-032 Assertion mid-operation discards all entries; no retire lane asserts in the first cycle after deassertion.

Verification
REQ-033 Reset, alloc 2 (AR 3/PR 40/Old 3; AR 5/PR 41/Old 5), Wb both -> two cycles later RetireNum=2, lanes 1,2 Able, AR 3/5, PR 40/41, OldPR 3/5.
REQ-034 Alloc 6, complete idx 0,1,2,4,5 -> RetireNum=3; idx 3 completed later -> next retire lanes idx 3,4,5, RetireNum=3.
REQ-035 Fill to 16 -> AllocReady=0, further AllocReq ignored, AllocIdx stable; retire 4 -> AllocReady=1; wrap-around alloc gets idx 0,1.
REQ-036 Entry with AllocDst=0 completes -> RetireNum=1, RetireReg1Able=0, RetireFree1=0.
REQ-037 Stop asserted with 4 complete entries -> no retire while Stop, all four retire the cycle after release; Flash with Stop=1 ignored.
REQ-038 Flash with 5 entries (3 complete) -> count 0, no retire output, next alloc gets idx 0; Rest pulse mid-retire -> outputs 0 immediately.
